// File: rtl/dual_port_ram_param.sv
// Parametrised simple dual-port RAM: one write port, one read port, one clock.
// Byte-lane write enables, selectable read-during-write policy, optional
// output register, and an init sequencer that fills every word with CLEAR_VAL
// after reset or on a clear request. User accesses are ignored while busy.
module dual_port_ram_param #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       OUT_REG   = 0,
  parameter int unsigned       RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W/8-1:0]   write_be,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [DATA_W-1:0]     read_data,
  output logic                  read_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LANES = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                user_wr;
  logic                user_rd;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [LANES-1:0]    mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;

  // User accesses are honoured only in READY and never on a clear edge
  always_comb begin
    user_wr = (state == ST_READY) && write_en && !clear;
    user_rd = (state == ST_READY) && read_en && !clear;
  end

  // Write-port mux: init sequencer owns the port while initialising
  always_comb begin
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_be    = '1;
      mem_wdata = CLEAR_VAL;
    end else begin
      mem_we    = user_wr;
      mem_waddr = write_addr;
      mem_be    = write_be;
      mem_wdata = write_data;
    end
  end

  // Read word selection, including same-address read-during-write forwarding
  always_comb begin
    old_word    = mem[read_addr];
    merged_word = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (write_be[i]) begin
        merged_word[8*i +: 8] = write_data[8*i +: 8];
      end
    end
    rd_word = old_word;
    if ((RDW_MODE != 0) && user_wr && (write_addr == read_addr)) begin
      rd_word = merged_word;
    end
  end

  // Storage array with per-lane write enables
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Init/ready control; the counter stops at DEPTH-1 rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (clear) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == '1) begin
        state <= ST_READY;
      end else begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
    end
  end

  // busy comes straight from the state register, so it is glitch-free
  always_comb begin
    busy = (state == ST_INIT);
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      // Single-stage read: data and valid update on the sampling edge
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          read_data  <= '0;
          read_valid <= 1'b0;
        end else begin
          read_valid <= user_rd;
          if (user_rd) begin
            read_data <= rd_word;
          end
        end
      end
    end else begin : g_out_reg
      logic [DATA_W-1:0] pipe_data;
      logic              pipe_valid;

      // Two-stage read; the second stage drains independently of state so
      // reads in flight at a clear still emerge
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_data  <= '0;
          pipe_valid <= 1'b0;
          read_data  <= '0;
          read_valid <= 1'b0;
        end else begin
          pipe_valid <= user_rd;
          if (user_rd) begin
            pipe_data <= rd_word;
          end
          read_valid <= pipe_valid;
          if (pipe_valid) begin
            read_data <= pipe_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: four instances (every OUT_REG/RDW_MODE pair)
// share one stimulus stream and are compared each cycle against a behavioural
// model, alongside directed literal expectations.
module tb_dual_port_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [3:0]  write_be;
  logic [31:0] write_data;
  logic        read_en;
  logic [3:0]  read_addr;

  logic [31:0] rd [4];
  logic        rv [4];
  logic        bz [4];

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Instance c has OUT_REG = c/2, RDW_MODE = c%2
  for (genvar c = 0; c < 4; c++) begin : g_dut
    dual_port_ram_param #(
      .DATA_W(32),
      .ADDR_W(4),
      .OUT_REG(c / 2),
      .RDW_MODE(c % 2),
      .CLEAR_VAL(32'h0000_0000)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .write_en(write_en),
      .write_addr(write_addr),
      .write_be(write_be),
      .write_data(write_data),
      .read_en(read_en),
      .read_addr(read_addr),
      .read_data(rd[c]),
      .read_valid(rv[c]),
      .busy(bz[c])
    );
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [16];
  int          m_busy_left;
  logic        h_v [2][2];   // [age in edges][rdw mode]
  logic [31:0] h_d [2][2];
  logic [31:0] e_data [4];
  logic        e_valid [4];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit          ready, acc_r, acc_w;
    logic [31:0] nv;
    logic [31:0] rres [2];
    if (rst) begin
      m_busy_left = 16;
      for (int a = 0; a < 2; a++)
        for (int m = 0; m < 2; m++) begin
          h_v[a][m] = 1'b0;
          h_d[a][m] = 32'h0;
        end
      for (int c = 0; c < 4; c++) begin
        e_data[c]  = 32'h0;
        e_valid[c] = 1'b0;
      end
    end else begin
      ready   = (m_busy_left == 0);
      acc_r   = ready && read_en && !clear;
      acc_w   = ready && write_en && !clear;
      nv      = merge(m_mem[write_addr], write_data, write_be);
      rres[0] = m_mem[read_addr];
      rres[1] = (acc_w && write_addr == read_addr) ? nv : m_mem[read_addr];
      if (!ready) begin
        m_mem[16 - m_busy_left] = 32'h0;
        m_busy_left--;
        if (clear) m_busy_left = 16;
      end else if (clear) begin
        m_busy_left = 16;
      end else if (acc_w) begin
        m_mem[write_addr] = nv;
      end
      for (int m = 0; m < 2; m++) begin
        h_v[1][m] = h_v[0][m];
        h_d[1][m] = h_d[0][m];
        h_v[0][m] = acc_r;
        h_d[0][m] = rres[m];
      end
      for (int c = 0; c < 4; c++) begin
        e_valid[c] = h_v[c / 2][c % 2];
        if (e_valid[c]) e_data[c] = h_d[c / 2][c % 2];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (rd[c] !== e_data[c] || rv[c] !== e_valid[c] || bz[c] !== (m_busy_left != 0)) begin
          failed++;
          $display("FAIL model_cfg%0d t=%0t: got data=%h valid=%b busy=%b, expected data=%h valid=%b busy=%b",
                   c, $time, rd[c], rv[c], bz[c], e_data[c], e_valid[c], (m_busy_left != 0));
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;
    write_be = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en = 1'b1; write_addr = a; write_data = d; write_be = be;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  // Presents a read (plus any write already set up) and checks both latencies
  task automatic read_check(input string name, input logic [3:0] a,
                            input logic [31:0] x0, input logic [31:0] x1);
    logic [31:0] x [2];
    x[0] = x0; x[1] = x1;
    read_en = 1'b1; read_addr = a;
    @(negedge clk);
    idle();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s_lat1_valid_c%0d", name, c), rv[c], 1);
      chk($sformatf("%s_lat1_data_c%0d", name, c), rd[c], x[c]);
      chk($sformatf("%s_lat1_novalid_c%0d", name, c + 2), rv[c + 2], 0);
    end
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s_lat2_valid_c%0d", name, c + 2), rv[c + 2], 1);
      chk($sformatf("%s_lat2_data_c%0d", name, c + 2), rd[c + 2], x[c]);
      chk($sformatf("%s_hold_valid_c%0d", name, c), rv[c], 0);
      chk($sformatf("%s_hold_data_c%0d", name, c), rd[c], x[c]);
    end
  endtask

  // Counts edges until busy falls; optionally pokes accesses meanwhile
  task automatic wait_init(input string name, input bit junk);
    int n;
    int vcnt;
    n = 0; vcnt = 0;
    while (1) begin
      if (junk && n < 10) begin
        write_en = 1'b1; write_addr = 4'd3; write_data = 32'hCAFE0000; write_be = 4'hF;
        read_en  = 1'b1; read_addr  = 4'd3;
      end else begin
        idle();
      end
      @(negedge clk);
      n++;
      for (int c = 0; c < 4; c++) if (rv[c] && bz[0]) vcnt++;
      if (!bz[0] || n > 40) break;
    end
    idle();
    chk($sformatf("%s_busy_edges", name), n, 16);
    chk($sformatf("%s_valid_during_init", name), vcnt, 0);
  endtask

  task automatic stream_read(input string name, input logic [31:0] last);
    int cnt [4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1; read_addr = 4'(i);
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (rv[c]) cnt[c]++;
    end
    read_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (rv[c]) cnt[c]++;
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_valid_count_c%0d", name, c), cnt[c], 16);
      chk($sformatf("%s_hold_last_c%0d", name, c), rd[c], last);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();
    write_addr = '0; write_data = '0; read_addr = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("reset_data_c%0d", c), rd[c], 32'h0);
      chk($sformatf("reset_valid_c%0d", c), rv[c], 0);
      chk($sformatf("reset_busy_c%0d", c), bz[c], 1);
    end

    // 1. reset release and init
    rst = 1'b0;
    wait_init("init_rst", 1'b0);
    stream_read("init_read", 32'h0);

    // 2. byte enables and latency
    wr(4'd5, 32'hDEADBEEF, 4'hF);
    wr(4'd5, 32'h0000AA00, 4'h2);
    read_check("byte_en", 4'd5, 32'hDEADAAEF, 32'hDEADAAEF);

    // 3. read-during-write
    wr(4'd7, 32'h11111111, 4'hF);
    write_en = 1'b1; write_addr = 4'd7; write_data = 32'h22222222; write_be = 4'hF;
    read_check("rdw_full", 4'd7, 32'h11111111, 32'h22222222);
    wr(4'd7, 32'h11111111, 4'hF);
    write_en = 1'b1; write_addr = 4'd7; write_data = 32'h22222222; write_be = 4'h1;
    read_check("rdw_lane0", 4'd7, 32'h11111111, 32'h11111122);

    // 6. streaming reads of distinct data
    for (int i = 0; i < 16; i++) wr(4'(i), {8'hA5, 8'(i), 8'(i * 3), 8'(~i)}, 4'hF);
    stream_read("stream", 32'hA50F2DF0);

    // 5/4. fill, read in flight, clear, accesses ignored while busy
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
    read_en = 1'b1; read_addr = 4'd2;
    @(negedge clk);
    read_addr = 4'd9; clear = 1'b1;
    @(negedge clk);
    idle();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("clear_drop_valid_c%0d", c), rv[c], 0);
      chk($sformatf("clear_inflight_valid_c%0d", c + 2), rv[c + 2], 1);
      chk($sformatf("clear_inflight_data_c%0d", c + 2), rd[c + 2], 32'hFFFFFFFF);
    end
    chk("clear_busy", bz[0], 1);
    wait_init("init_clear", 1'b1);
    read_check("after_init_a3", 4'd3, 32'h0, 32'h0);
    stream_read("clear_read", 32'h0);

    // 5. asynchronous reset with a read in flight
    wr(4'd4, 32'h12345678, 4'hF);
    read_en = 1'b1; read_addr = 4'd4;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("async_rst_data_c%0d", c), rd[c], 32'h0);
      chk($sformatf("async_rst_valid_c%0d", c), rv[c], 0);
      chk($sformatf("async_rst_busy_c%0d", c), bz[c], 1);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_init("init_rst2", 1'b0);
    stream_read("rst2_read", 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
